systolic_mm_stream: RTL and testbench

//  Output-stationary MxN systolic matrix multiplier with streamed operands and runtime K length.

---
 rtl/systolic_mm_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_systolic_mm_stream.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_stream.sv
// systolic_mm_stream: output-stationary MxN systolic matmul, streamed A/B beats, C rows out over valid/ready.
// Define ACC_SATURATE_EN for saturating accumulation with a sticky ovf flag; otherwise accumulators wrap.
module systolic_mm_stream #(
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int MAX_K      = 256,
  parameter int SIGNED     = 1,
  localparam int KW        = $clog2(MAX_K + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [KW-1:0]             cfg_k_i,
  output logic                      busy_o,
  input  logic                      a_valid_i,
  output logic                      a_ready_o,
  input  logic [M*DATA_WIDTH-1:0]   a_col_i,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [N*DATA_WIDTH-1:0]   b_row_i,
  output logic                      c_valid_o,
  input  logic                      c_ready_i,
  output logic [N*ACC_WIDTH-1:0]    c_row_o,
  output logic                      c_last_o,
  output logic                      done_o,
  output logic                      ovf_o
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int RW = M > 1 ? $clog2(M) : 1;
  localparam int FW = $clog2(M + N);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fl_q, fl_d;
  logic [RW-1:0]   r_q, r_d;
  logic            done_q, done_d;
  logic            fire, clr;
  logic [DW-1:0]   a_w [M][N];
  logic [DW-1:0]   b_w [M][N];
  logic            t_w [M][N];
  logic [AW-1:0]   acc_w [M][N];

  // Operands are widened to 2*DW before multiplying, so one unsigned multiply serves both signednesses.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    logic            s;
    s = SIGNED != 0;
    p = {{DW{s & a[DW-1]}}, a} * {{DW{s & b[DW-1]}}, b};
    return AW'({{AW{s & p[2*DW-1]}}, p});
  endfunction

`ifdef ACC_SATURATE_EN
  // Returns {clamped, sum}.
  function automatic logic [AW:0] sat_add(input logic [AW-1:0] acc, input logic [AW-1:0] p);
    logic [AW:0] s;
    if (SIGNED != 0) begin
      s = {acc[AW-1], acc} + {p[AW-1], p};
      return (s[AW] != s[AW-1]) ? {1'b1, s[AW], {(AW-1){~s[AW]}}} : {1'b0, s[AW-1:0]};
    end
    s = {1'b0, acc} + {1'b0, p};
    return s[AW] ? {1'b1, {AW{1'b1}}} : {1'b0, s[AW-1:0]};
  endfunction

  logic [M*N-1:0] sat_v;
  logic           ovf_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= clr ? 1'b0 : (ovf_q | (|sat_v));

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign fire      = state_q == FEED && a_valid_i && b_valid_i;
  assign clr       = state_q == IDLE && start_i;
  assign a_ready_o = fire;
  assign b_ready_o = fire;
  assign busy_o    = state_q != IDLE;
  assign c_valid_o = state_q == DRAIN;
  assign c_last_o  = c_valid_o && r_q == RW'(M - 1);
  assign done_o    = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        cnt_d   = cfg_k_i > KW'(MAX_K) ? KW'(MAX_K) : cfg_k_i;
        r_d     = '0;
        state_d = cfg_k_i == '0 ? DRAIN : FEED;
      end
      FEED: if (fire) begin
        cnt_d = cnt_q - KW'(1);
        if (cnt_q == KW'(1)) begin
          state_d = FLUSH;
          fl_d    = '0;
        end
      end
      FLUSH: begin
        fl_d    = fl_q + FW'(1);
        state_d = fl_q == FW'(M + N - 2) ? DRAIN : FLUSH;
      end
      DRAIN: if (c_ready_i) begin
        r_d = r_q + RW'(1);
        if (r_q == RW'(M - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fl_q    <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end

  always_comb begin
    c_row_o = '0;
    for (int j = 0; j < N; j++) c_row_o[j*AW +: AW] = c_valid_o ? acc_w[r_q][j] : '0;
  end

  // Row i of A is delayed i cycles, tag alongside, so the wavefront meets B on the diagonal.
  for (genvar i = 0; i < M; i++) begin : g_ask
    if (i == 0) begin : g_0
      assign a_w[i][0] = a_col_i[0 +: DW];
      assign t_w[i][0] = fire;
    end else begin : g_d
      logic [DW-1:0] d_q [i];
      logic          v_q [i];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            d_q[s] <= '0;
            v_q[s] <= 1'b0;
          end
        end else begin
          d_q[0] <= a_col_i[i*DW +: DW];
          v_q[0] <= fire;
          for (int s = 1; s < i; s++) begin
            d_q[s] <= d_q[s-1];
            v_q[s] <= v_q[s-1];
          end
        end
      assign a_w[i][0] = d_q[i-1];
      assign t_w[i][0] = v_q[i-1];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_bsk
    if (j == 0) begin : g_0
      assign b_w[0][j] = b_row_i[0 +: DW];
    end else begin : g_d
      logic [DW-1:0] d_q [j];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int s = 0; s < j; s++) d_q[s] <= '0;
        end else begin
          d_q[0] <= b_row_i[j*DW +: DW];
          for (int s = 1; s < j; s++) d_q[s] <= d_q[s-1];
        end
      assign b_w[0][j] = d_q[j-1];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_pr
    for (genvar j = 0; j < N; j++) begin : g_pc
      logic [AW-1:0] acc_q, acc_nx, prod;
      assign prod = mul_ext(a_w[i][j], b_w[i][j]);
`ifdef ACC_SATURATE_EN
      logic sat;
      assign {sat, acc_nx}  = sat_add(acc_q, prod);
      assign sat_v[i*N + j] = t_w[i][j] & sat;
`else
      assign acc_nx = acc_q + prod;
`endif
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)         acc_q <= '0;
        else if (clr)       acc_q <= '0;
        else if (t_w[i][j]) acc_q <= acc_nx;
      assign acc_w[i][j] = acc_q;
      if (j < N - 1) begin : g_e
        logic [DW-1:0] a_q;
        logic          t_q;
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) begin
            a_q <= '0;
            t_q <= 1'b0;
          end else begin
            a_q <= a_w[i][j];
            t_q <= t_w[i][j];
          end
        assign a_w[i][j+1] = a_q;
        assign t_w[i][j+1] = t_q;
      end
      if (i < M - 1) begin : g_s
        logic [DW-1:0] b_q;
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) b_q <= '0;
          else        b_q <= b_w[i][j];
        assign b_w[i+1][j] = b_q;
      end
    end
  end
endmodule

// File: tb/tb_systolic_mm_stream.sv
// tb_systolic_mm_stream: random jobs against a plain-arithmetic matrix product model; covers
// stalls, C back-pressure, K=0, K clamp, overflow corner and mid-job reset.
module tb_systolic_mm_stream;
  localparam int M = 4, N = 4, DW = 16, AW = 32, MAXK = 8, KW = 4;

  logic            clk = 1'b0;
  logic            rst_n, start, busy, a_valid, a_ready, b_valid, b_ready;
  logic            c_valid, c_ready, c_last, done, ovf;
  logic [KW-1:0]   cfg_k;
  logic [M*DW-1:0] a_col;
  logic [N*DW-1:0] b_row;
  logic [N*AW-1:0] c_row;

  int checks = 0, errors = 0;
  logic [DW-1:0]   av [MAXK][M];
  logic [DW-1:0]   bv [MAXK][N];
  logic [N*AW-1:0] exp_row [M];
  logic            exp_ovf;

  always #5 clk = ~clk;

  systolic_mm_stream #(.M(M), .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_K(MAXK), .SIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .cfg_k_i(cfg_k), .busy_o(busy),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_col_i(a_col),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_row_i(b_row),
    .c_valid_o(c_valid), .c_ready_i(c_ready), .c_row_o(c_row), .c_last_o(c_last),
    .done_o(done), .ovf_o(ovf)
  );

  task automatic check_val(input string tag, input logic [N*AW-1:0] got, input logic [N*AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: fresh random, 1: keep previous data, 2: every element -32768
  task automatic gen(input int kk, input int mode);
    if (mode == 1) return;
    for (int k = 0; k < kk; k++)
      for (int i = 0; i < M; i++) begin
        av[k][i] = mode == 2 ? 16'h8000 : DW'($urandom);
        bv[k][i] = mode == 2 ? 16'h8000 : DW'($urandom);
      end
  endtask

  task automatic model(input int kk);
    longint acc;
    exp_ovf = 1'b0;
    for (int r = 0; r < M; r++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < kk; k++) begin
          acc += longint'($signed(av[k][r])) * longint'($signed(bv[k][j]));
`ifdef ACC_SATURATE_EN
          if (acc > 64'sh7FFFFFFF) begin
            acc = 64'sh7FFFFFFF;
            exp_ovf = 1'b1;
          end else if (acc < -64'sh80000000) begin
            acc = -64'sh80000000;
            exp_ovf = 1'b1;
          end
`endif
        end
        exp_row[r][j*AW +: AW] = AW'(acc);
      end
  endtask

  task automatic run_job(input int kreq, input int vpct, input int hold_row, input bit chk_lat);
    int kk, beat, r, held;
    bit fin, seen, hs, cfire;
    kk = kreq > MAXK ? MAXK : kreq;
    model(kk);
    @(negedge clk);
    start = 1'b1;
    cfg_k = KW'(kreq);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("ovf_clr", ovf, 0);
    check_val("busy_run", busy, 1);
    beat = 0; r = 0; held = 0; fin = 0; seen = 0;
    for (int n = 0; n < 400 && !fin; n++) begin
      a_valid = beat < kk && $urandom_range(99) < vpct;
      b_valid = beat < kk && $urandom_range(99) < vpct;
      for (int i = 0; i < M; i++) begin
        a_col[i*DW +: DW] = DW'($urandom);
        b_row[i*DW +: DW] = DW'($urandom);
        if (beat < kk) begin
          a_col[i*DW +: DW] = av[beat][i];
          b_row[i*DW +: DW] = bv[beat][i];
        end
      end
      c_ready = !(r == hold_row && held < 5);
      #1;
      if (beat < kk) check_val("joint_hs", {a_ready, b_ready}, {2{a_valid & b_valid}});
      hs = a_ready;
      cfire = c_valid && c_ready;
      if (c_valid) begin
        if (!seen && chk_lat) check_val("latency", n + 1, kk + M + N);
        seen = 1;
        check_val($sformatf("row%0d", r), c_row, exp_row[r]);
        check_val("c_last", c_last, r == M - 1);
        if (!c_ready) held++;
      end
      @(posedge clk);
      if (hs) beat++;
      if (cfire) begin
        r++;
        fin = r == M;
      end
      @(negedge clk);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (!fin) check_val("timeout", 0, 1);
    check_val("done", done, 1);
    check_val("busy_end", busy, 0);
    check_val("c_valid_end", c_valid, 0);
    check_val("ovf", ovf, exp_ovf);
    @(negedge clk);
    check_val("done_pulse", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_k = '0; a_valid = 1'b0; b_valid = 1'b0;
    a_col = '0; b_row = '0; c_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_flags", {busy, a_ready, b_ready, c_valid, c_last, done, ovf}, 0);
    check_val("rst_c_row", c_row, 0);
    rst_n = 1'b1;
    gen(6, 0); run_job(6, 100, -1, 1);
    gen(6, 1); run_job(6, 50, -1, 0);
    gen(6, 0); run_job(6, 100, 2, 1);
    run_job(0, 100, -1, 0);
    gen(4, 2); run_job(4, 100, -1, 1);
    repeat (3) @(negedge clk);
    check_val("ovf_sticky", ovf, exp_ovf);
    gen(MAXK, 0); run_job(12, 100, -1, 1);
    gen(6, 0);
    @(negedge clk);
    start = 1'b1;
    cfg_k = KW'(6);
    @(negedge clk);
    start = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_col = M*DW'($urandom);
    b_row = N*DW'($urandom);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_flags", {busy, a_ready, b_ready, c_valid, c_last, done, ovf}, 0);
    check_val("midrst_c_row", c_row, 0);
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b1;
    gen(2, 0); run_job(2, 100, -1, 1);
    repeat (4) begin
      int k;
      k = $urandom_range(1, MAXK);
      gen(k, 0);
      run_job(k, $urandom_range(30, 100), $urandom_range(0, M - 1), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
